// File: rtl/alu_sequencer_if.sv
// Instruction-in and response-out handshake bundle for alu_sequencer.
// master = producer/consumer side, slave = the sequencer.
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_wen;
  logic        res_branch_taken;
  logic        res_overflow;
  logic        res_illegal;

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, res_ready,
    input  in_ready, res_valid, res_data, res_rd, res_wen,
           res_branch_taken, res_overflow, res_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, res_ready,
    output in_ready, res_valid, res_data, res_rd, res_wen,
           res_branch_taken, res_overflow, res_illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle execute sequencer: accepts an instruction, decodes the ALU control,
// drives the external combinational ALU, and returns a writeback/branch response.
module alu_sequencer (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    bus,
  output logic [5:0]        alu_control,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_out,
  input  logic              alu_zero,
  input  logic              alu_overflow
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  localparam logic [5:0] RFUNCT [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};

  state_t      state_reg, state_next;

  logic [5:0]  op_reg;
  logic [4:0]  rt_idx_reg;
  logic [15:0] imm_reg;
  logic [31:0] rs_val_reg, rt_val_reg;

  logic [5:0]  alu_control_reg;
  logic [31:0] alu_a_reg, alu_b_reg;
  logic [4:0]  dest_reg;
  logic        wen_reg, illegal_reg, branch_reg, ovchk_reg;

  logic [31:0] res_data_reg;
  logic [4:0]  res_rd_reg;
  logic        res_wen_reg, res_branch_reg, res_overflow_reg, res_illegal_reg;

  logic [5:0]  dec_control;
  logic [31:0] dec_b;
  logic [4:0]  dec_dest;
  logic        dec_wen, dec_illegal, dec_branch, dec_ovchk;
  logic [5:0]  funct_hit;
  logic        exec_ov;

  // rs index is never needed here; the register file already resolved it.
  logic unused_rs_field;
  assign unused_rs_field = ^bus.in_instr[25:21];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_funct
      assign funct_hit[gi] = (imm_reg[5:0] == RFUNCT[gi]);
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.res_valid = (state_reg == RESP);
  end

  always_comb begin
    dec_control = '0;
    dec_b       = '0;
    dec_dest    = '0;
    dec_wen     = 1'b0;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    case (op_reg)
      6'd0: begin
        if (|funct_hit) begin
          dec_control = imm_reg[5:0];
          dec_b       = rt_val_reg;
          dec_dest    = imm_reg[15:11];
          dec_wen     = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'd8, 6'd10: begin
        dec_control = op_reg;
        dec_b       = {{16{imm_reg[15]}}, imm_reg};
        dec_dest    = rt_idx_reg;
        dec_wen     = 1'b1;
      end
      6'd12, 6'd13: begin
        dec_control = op_reg;
        dec_b       = {16'h0000, imm_reg};
        dec_dest    = rt_idx_reg;
        dec_wen     = 1'b1;
      end
      6'd4, 6'd5: begin
        dec_control = op_reg;
        dec_b       = rt_val_reg;
        dec_branch  = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Only add and addi are allowed to raise an overflow exception.
  assign dec_ovchk = (dec_control == 6'd32) || (dec_control == 6'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg     <= '0;
      rt_idx_reg <= '0;
      imm_reg    <= '0;
      rs_val_reg <= '0;
      rt_val_reg <= '0;
    end else if (state_reg == IDLE && bus.in_valid) begin
      op_reg     <= bus.in_instr[31:26];
      rt_idx_reg <= bus.in_instr[20:16];
      imm_reg    <= bus.in_instr[15:0];
      rs_val_reg <= bus.in_rs_val;
      rt_val_reg <= bus.in_rt_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_control_reg <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      dest_reg        <= '0;
      wen_reg         <= 1'b0;
      illegal_reg     <= 1'b0;
      branch_reg      <= 1'b0;
      ovchk_reg       <= 1'b0;
    end else if (state_reg == DECODE) begin
      alu_control_reg <= dec_control;
      alu_a_reg       <= rs_val_reg;
      alu_b_reg       <= dec_b;
      dest_reg        <= dec_dest;
      wen_reg         <= dec_wen;
      illegal_reg     <= dec_illegal;
      branch_reg      <= dec_branch;
      ovchk_reg       <= dec_ovchk;
    end
  end

  assign exec_ov = ovchk_reg & alu_overflow;

  // Response fields are captured once in EXEC and then held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_reg     <= '0;
      res_rd_reg       <= '0;
      res_wen_reg      <= 1'b0;
      res_branch_reg   <= 1'b0;
      res_overflow_reg <= 1'b0;
      res_illegal_reg  <= 1'b0;
    end else if (state_reg == EXEC) begin
      res_data_reg     <= alu_out;
      res_rd_reg       <= dest_reg;
      res_wen_reg      <= wen_reg & ~exec_ov;
      res_branch_reg   <= branch_reg & alu_zero;
      res_overflow_reg <= exec_ov;
      res_illegal_reg  <= illegal_reg;
    end
  end

  assign alu_control          = alu_control_reg;
  assign alu_a                = alu_a_reg;
  assign alu_b                = alu_b_reg;
  assign bus.res_data         = res_data_reg;
  assign bus.res_rd           = res_rd_reg;
  assign bus.res_wen          = res_wen_reg;
  assign bus.res_branch_taken = res_branch_reg;
  assign bus.res_overflow     = res_overflow_reg;
  assign bus.res_illegal      = res_illegal_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases from the test plan plus
// randomized instructions, checked against an instruction-level reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero, alu_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_control  (alu_control),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] b;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        taken;
    logic        ovf;
    logic        ill;
  } exp_t;

  // The datapath ALU this sequencer talks to: {overflow, zero, result}.
  function automatic logic [33:0] alu_env(logic [5:0] c, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic        ov, z;
    r  = '0;
    ov = 1'b0;
    case (c)
      6'd32, 6'd8: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      6'd34, 6'd4, 6'd5: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      6'd36, 6'd12: r = a & b;
      6'd37, 6'd13: r = a | b;
      6'd39: r = ~(a | b);
      6'd42, 6'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    z = (c == 6'd5) ? (r != 0) : (r == 0);
    return {ov, z, r};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_out} = alu_env(alu_control, alu_a, alu_b);

  // Instruction-level reference: what the response must be for this instruction.
  function automatic exp_t ref_model(logic [31:0] instr, logic [31:0] rs, logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op, fn;
    logic [15:0] imm;
    logic        is_br, is_add;
    logic [33:0] r;
    op = instr[31:26];
    fn = instr[5:0];
    imm = instr[15:0];
    e = '0;
    is_br = 1'b0;
    if (op == 0 && fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42}) begin
      e.ctrl = fn; e.b = rt; e.rd = instr[15:11]; e.wen = 1'b1;
    end else if (op == 8 || op == 10) begin
      e.ctrl = op; e.b = 32'($signed(imm)); e.rd = instr[20:16]; e.wen = 1'b1;
    end else if (op == 12 || op == 13) begin
      e.ctrl = op; e.b = 32'(imm); e.rd = instr[20:16]; e.wen = 1'b1;
    end else if (op == 4 || op == 5) begin
      e.ctrl = op; e.b = rt; is_br = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    r = alu_env(e.ctrl, rs, e.b);
    is_add = (e.ctrl == 6'd32) || (e.ctrl == 6'd8);
    e.data  = r[31:0];
    e.taken = is_br & r[32];
    e.ovf   = is_add & r[33];
    if (e.ovf) e.wen = 1'b0;
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_res(string tag, exp_t e);
    check({tag, "_valid"}, bus.res_valid, 1);
    check({tag, "_data"}, bus.res_data, e.data);
    check({tag, "_rd"}, bus.res_rd, e.rd);
    check({tag, "_wen"}, bus.res_wen, e.wen);
    check({tag, "_taken"}, bus.res_branch_taken, e.taken);
    check({tag, "_ovf"}, bus.res_overflow, e.ovf);
    check({tag, "_ill"}, bus.res_illegal, e.ill);
    check({tag, "_inrdy"}, bus.in_ready, 0);
  endtask

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Entered and left at a negedge. hold = cycles of res_ready low in RESP.
  task automatic run_txn(logic [31:0] instr, logic [31:0] rs, logic [31:0] rt, int hold);
    exp_t e;
    int   k;
    e = ref_model(instr, rs, rt);
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_rdy", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
    bus.res_ready = 1'($urandom_range(0, 1));
    @(posedge clk);                       // E0 accept
    @(negedge clk);
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_instr = $urandom;
    check("dec_inrdy", bus.in_ready, 0);
    check("dec_rvalid", bus.res_valid, 0);
    @(posedge clk);                       // E1 decode registered
    @(negedge clk);
    check("alu_ctrl", alu_control, e.ctrl);
    check("alu_a", alu_a, rs);
    check("alu_b", alu_b, e.b);
    check("exec_rvalid", bus.res_valid, 0);
    @(posedge clk);                       // E2 result captured
    @(negedge clk);
    check_res("resp", e);
    bus.res_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = $urandom;
      @(posedge clk);
      @(negedge clk);
      check_res("hold", e);
      check("hold_ctrl", alu_control, e.ctrl);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);                       // E3 response taken
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("done_rvalid", bus.res_valid, 0);
    check("done_inrdy", bus.in_ready, 1);
    n_txn++;
    $display("txn %0d instr=%h rs=%h rt=%h hold=%0d -> data=%h rd=%0d wen=%b br=%b ov=%b ill=%b",
             n_txn, instr, rs, rt, hold, bus.res_data, bus.res_rd, bus.res_wen,
             bus.res_branch_taken, bus.res_overflow, bus.res_illegal);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_inrdy"}, bus.in_ready, 1);
    check({tag, "_rvalid"}, bus.res_valid, 0);
    check({tag, "_data"}, bus.res_data, 0);
    check({tag, "_rd"}, bus.res_rd, 0);
    check({tag, "_flags"}, {bus.res_wen, bus.res_branch_taken, bus.res_overflow, bus.res_illegal}, 0);
    check({tag, "_ctrl"}, alu_control, 0);
    check({tag, "_a"}, alu_a, 0);
    check({tag, "_b"}, alu_b, 0);
  endtask

  task automatic random_txn();
    logic [31:0] instr, rs, rt;
    logic [5:0]  fn;
    logic [5:0]  legal [6];
    legal = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    rs = $urandom;
    rt = $urandom;
    fn = legal[$urandom_range(0, 5)];
    case ($urandom_range(0, 7))
      0: instr = rtype(5'($urandom), 5'($urandom), 5'($urandom), fn);
      1: instr = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
      2: instr = itype(($urandom_range(0, 1) != 0) ? 6'd8 : 6'd10, 5'($urandom), 5'($urandom), 16'($urandom));
      3: instr = itype(($urandom_range(0, 1) != 0) ? 6'd12 : 6'd13, 5'($urandom), 5'($urandom), 16'($urandom));
      4: begin
        instr = itype(($urandom_range(0, 1) != 0) ? 6'd4 : 6'd5, 5'($urandom), 5'($urandom), 16'($urandom));
        if ($urandom_range(0, 1) != 0) rt = rs;
      end
      5: instr = $urandom;
      6: begin
        instr = itype(6'd8, 5'($urandom), 5'($urandom), 16'($urandom_range(0, 255)));
        rs = 32'h7FFF_FF80 + 32'($urandom_range(0, 255));
      end
      default: begin
        instr = rtype(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 1) != 0) ? 6'd32 : 6'd34);
        rs = {1'b0, 31'($urandom)} | 32'h7000_0000;
        rt = ($urandom_range(0, 1) != 0) ? rs : ~rs;
      end
    endcase
    run_txn(instr, rs, rt, $urandom_range(0, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("por");

    run_txn(rtype(5'd1, 5'd2, 5'd3, 6'd32), 32'd5, 32'd7, 0);
    check("add_data", bus.res_data, 32'd12);
    run_txn(itype(6'd8, 5'd4, 5'd9, 16'hFFFF), 32'd10, 32'd0, 0);
    check("addi_b", alu_b, 32'hFFFF_FFFF);
    run_txn(itype(6'd13, 5'd4, 5'd9, 16'h8000), 32'd10, 32'd0, 1);
    check("ori_b", alu_b, 32'h0000_8000);
    run_txn(itype(6'd4, 5'd1, 5'd2, 16'h0010), 32'h55, 32'h55, 0);
    check("beq_taken", bus.res_branch_taken, 1);
    run_txn(itype(6'd5, 5'd1, 5'd2, 16'h0010), 32'h55, 32'h55, 0);
    check("bne_taken", bus.res_branch_taken, 0);
    run_txn(itype(6'd8, 5'd1, 5'd6, 16'h0001), 32'h7FFF_FFFF, 32'd0, 0);
    check("addi_ovf", {bus.res_overflow, bus.res_wen}, 2'b10);
    run_txn(rtype(5'd1, 5'd2, 5'd3, 6'd34), 32'h8000_0000, 32'd1, 0);
    check("sub_noovf", bus.res_overflow, 0);
    run_txn(itype(6'd35, 5'd1, 5'd2, 16'h0004), 32'd100, 32'd0, 0);
    check("lw_illegal", {bus.res_illegal, bus.res_wen}, 2'b10);
    check("lw_ctrl", alu_control, 0);
    run_txn(rtype(5'd7, 5'd8, 5'd31, 6'd37), 32'hF0F0_0000, 32'h0000_0F0F, 5);

    // Reset held two cycles while the instruction is in EXEC.
    bus.in_valid  = 1'b1;
    bus.in_instr  = rtype(5'd1, 5'd2, 5'd4, 6'd32);
    bus.in_rs_val = 32'd3;
    bus.in_rt_val = 32'd4;
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midrst");
    repeat (4) begin
      @(negedge clk);
      check("midrst_novalid", bus.res_valid, 0);
    end

    for (int t = 0; t < 40; t++) random_txn();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
